// File: rtl/konami_audio_pkg.sv
// Shared types and sizing helpers for the Konami audio mixer.
package konami_audio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } mixer_state_t;

  localparam logic [7:0] GAIN_UNITY = 8'h10;

  // Product of an (in_w+2)-bit sample and an 8-bit gain, plus headroom for every channel.
  function automatic int acc_width(input int in_w, input int channels);
    return in_w + 10 + $clog2(channels);
  endfunction

endpackage

// File: rtl/konami_dcrm_bank.sv
// Per-channel DC trackers; reads the DC-corrected sample of channel idx and
// optionally folds it back into that channel's tracker.
module konami_dcrm_bank
  import konami_audio_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int IN_W       = 16,
  parameter int DCRM_SHIFT = 10,
  parameter int IDX_W      = 2
) (
  input  logic                   clk_49m,
  input  logic                   reset,
  input  logic [IDX_W-1:0]       idx,
  input  logic signed [IN_W-1:0] x,
  input  logic                   en,
  input  logic                   upd,
  output logic signed [IN_W:0]   y
);

  localparam int TRK_W = IN_W + DCRM_SHIFT;

  logic signed [TRK_W-1:0] trk_q [CHANNELS];
  logic signed [TRK_W-1:0] trk_d [CHANNELS];
  logic signed [IN_W-1:0]  dc_s;

  // Read port and tracker update; the top bits of the tracker are acc >>> DCRM_SHIFT.
  always_comb begin
    trk_d = trk_q;
    dc_s  = trk_q[idx][TRK_W-1:DCRM_SHIFT];
    if (en) begin
      y = {x[IN_W-1], x} - {dc_s[IN_W-1], dc_s};
    end else begin
      y = {x[IN_W-1], x};
    end
    if (upd && en) begin
      trk_d[idx] = trk_q[idx] + TRK_W'(y);
    end else begin
      trk_d[idx] = trk_q[idx];
    end
  end

  // Tracker registers.
  always_ff @(posedge clk_49m) begin
    if (reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        trk_q[k] <= '0;
      end
    end else begin
      trk_q <= trk_d;
    end
  end

endmodule

// File: rtl/konami_audio_mixer.sv
// Time-multiplexed N-channel mixer: per-channel DC removal, inversion and Q4.4 gain,
// summed and saturated into one registered sample per sample strobe.
module konami_audio_mixer
  import konami_audio_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int IN_W       = 16,
  parameter int OUT_W      = 16,
  parameter int DCRM_SHIFT = 10
) (
  input  logic                       clk_49m,
  input  logic                       reset,
  input  logic                       sample_cen,
  input  logic [CHANNELS*IN_W-1:0]   ch_in,
  input  logic [CHANNELS*8-1:0]      ch_gain,
  input  logic [CHANNELS-1:0]        ch_invert,
  input  logic [CHANNELS-1:0]        ch_dcrm_en,
  input  logic                       mute,
  input  logic                       clip_clr,
  output logic signed [OUT_W-1:0]    sound,
  output logic                       sample_valid,
  output logic                       clip,
  output logic                       overrun
);

  localparam int GAIN_W    = 8;
  localparam int GAIN_FRAC = 4;
  localparam int IDX_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PROD_W    = IN_W + 10;
  localparam int ACC_W     = acc_width(IN_W, CHANNELS);
  localparam int OUT_MAX   = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
  localparam int OUT_MIN   = -(32'sd1 <<< (OUT_W - 1));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  mixer_state_t                state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [CHANNELS*IN_W-1:0]    in_q, in_d;
  logic [CHANNELS*GAIN_W-1:0]  gain_q, gain_d;
  logic [CHANNELS-1:0]         inv_q, inv_d;
  logic [CHANNELS-1:0]         dcrm_q, dcrm_d;
  logic signed [ACC_W-1:0]     sum_q, sum_d;
  logic signed [OUT_W-1:0]     sound_q, sound_d;
  logic                        valid_q, valid_d;
  logic                        clip_q, clip_d;
  logic                        overrun_q, overrun_d;

  logic signed [IN_W-1:0]      x_s;
  logic [GAIN_W-1:0]           g_s;
  logic                        inv_s;
  logic                        en_s;
  logic                        upd_s;
  logic signed [IN_W:0]        y_s;
  logic signed [IN_W+1:0]      z_s;
  logic signed [PROD_W-1:0]    p_s;
  logic signed [ACC_W-1:0]     r_s;
  logic                        sat_hi_s;
  logic                        sat_lo_s;

  konami_dcrm_bank #(
    .CHANNELS   (CHANNELS),
    .IN_W       (IN_W),
    .DCRM_SHIFT (DCRM_SHIFT),
    .IDX_W      (IDX_W)
  ) u_dcrm (
    .clk_49m (clk_49m),
    .reset   (reset),
    .idx     (idx_q),
    .x       (x_s),
    .en      (en_s),
    .upd     (upd_s),
    .y       (y_s)
  );

  // Channel select, invert, gain and output scaling/saturation.
  always_comb begin
    x_s      = in_q[int'(idx_q)*IN_W +: IN_W];
    g_s      = gain_q[int'(idx_q)*GAIN_W +: GAIN_W];
    inv_s    = inv_q[idx_q];
    en_s     = dcrm_q[idx_q];
    upd_s    = (state_q == ACCUM);
    z_s      = inv_s ? -((IN_W+2)'(y_s)) : (IN_W+2)'(y_s);
    p_s      = PROD_W'(z_s) * PROD_W'($signed({1'b0, g_s}));
    r_s      = sum_q >>> GAIN_FRAC;
    sat_hi_s = (r_s > ACC_W'(OUT_MAX));
    sat_lo_s = (r_s < ACC_W'(OUT_MIN));
  end

  // FSM next state, accumulator, output sample and sticky flags.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    in_d    = in_q;
    gain_d  = gain_q;
    inv_d   = inv_q;
    dcrm_d  = dcrm_q;
    sum_d   = sum_q;
    sound_d = sound_q;
    valid_d = 1'b0;
    clip_d  = clip_clr ? 1'b0 : clip_q;

    case (state_q)
      IDLE: begin
        if (sample_cen) begin
          in_d    = ch_in;
          gain_d  = ch_gain;
          inv_d   = ch_invert;
          dcrm_d  = ch_dcrm_en;
          sum_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        sum_d = sum_q + ACC_W'(p_s);
        if (idx_q == LAST_IDX) begin
          state_d = OUTPUT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      OUTPUT: begin
        valid_d = 1'b1;
        state_d = IDLE;
        // Mute skips clip evaluation entirely; set beats clip_clr otherwise.
        if (mute) begin
          sound_d = '0;
        end else if (sat_hi_s) begin
          sound_d = {1'b0, {(OUT_W-1){1'b1}}};
          clip_d  = 1'b1;
        end else if (sat_lo_s) begin
          sound_d = {1'b1, {(OUT_W-1){1'b0}}};
          clip_d  = 1'b1;
        end else begin
          sound_d = r_s[OUT_W-1:0];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (sample_cen && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (clip_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State, snapshot and output registers.
  always_ff @(posedge clk_49m) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      in_q      <= '0;
      gain_q    <= '0;
      inv_q     <= '0;
      dcrm_q    <= '0;
      sum_q     <= '0;
      sound_q   <= '0;
      valid_q   <= 1'b0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      in_q      <= in_d;
      gain_q    <= gain_d;
      inv_q     <= inv_d;
      dcrm_q    <= dcrm_d;
      sum_q     <= sum_d;
      sound_q   <= sound_d;
      valid_q   <= valid_d;
      clip_q    <= clip_d;
      overrun_q <= overrun_d;
    end
  end

  assign sound        = sound_q;
  assign sample_valid = valid_q;
  assign clip         = clip_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_konami_audio_mixer.sv
// Directed bench for konami_audio_mixer with hand-computed expected samples.
module tb_konami_audio_mixer;
  import konami_audio_pkg::*;

  localparam int CH = 4;
  localparam int W  = 16;

  logic                 clk_49m = 1'b0;
  logic                 reset;
  logic                 sample_cen;
  logic [CH*W-1:0]      ch_in;
  logic [CH*8-1:0]      ch_gain;
  logic [CH-1:0]        ch_invert;
  logic [CH-1:0]        ch_dcrm_en;
  logic                 mute;
  logic                 clip_clr;
  logic signed [W-1:0]  sound;
  logic                 sample_valid;
  logic                 clip;
  logic                 overrun;

  int total = 0;
  int bad   = 0;

  int                   lat, pulses;
  logic signed [W-1:0]  snd, prev;
  logic                 clp;

  always #10 clk_49m = ~clk_49m;

  konami_audio_mixer #(
    .CHANNELS   (CH),
    .IN_W       (W),
    .OUT_W      (W),
    .DCRM_SHIFT (4)
  ) dut (
    .clk_49m      (clk_49m),
    .reset        (reset),
    .sample_cen   (sample_cen),
    .ch_in        (ch_in),
    .ch_gain      (ch_gain),
    .ch_invert    (ch_invert),
    .ch_dcrm_en   (ch_dcrm_en),
    .mute         (mute),
    .clip_clr     (clip_clr),
    .sound        (sound),
    .sample_valid (sample_valid),
    .clip         (clip),
    .overrun      (overrun)
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int k, input int val, input logic [7:0] gain, input logic inv, input logic en);
    logic [W-1:0] v;
    v = W'(val);
    ch_in[k*W +: W]   = v;
    ch_gain[k*8 +: 8] = gain;
    ch_invert[k]      = inv;
    ch_dcrm_en[k]     = en;
  endtask

  task automatic clear_ch();
    ch_in      = '0;
    ch_gain    = '0;
    ch_invert  = '0;
    ch_dcrm_en = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk_49m);
    #1 reset = 1'b0;
  endtask

  // Strobe in cycle t, then watch cycles t+1..t+12; *_cyc = 0 disables that event.
  task automatic do_pass(input int mute_cyc, input int restrobe_cyc, input int reset_cyc,
                         output int o_lat, output int o_pulses,
                         output logic signed [W-1:0] o_snd, output logic o_clp);
    int cyc;
    o_lat = 0; o_pulses = 0; o_snd = '0; o_clp = 1'b0;
    sample_cen = 1'b1;
    @(posedge clk_49m); #1;
    sample_cen = 1'b0;
    cyc = 1;
    repeat (12) begin
      sample_cen = (cyc == restrobe_cyc);
      mute       = (cyc == mute_cyc);
      reset      = (cyc == reset_cyc);
      if (sample_valid) begin
        o_pulses++;
        if (o_lat == 0) begin
          o_lat = cyc;
          o_snd = sound;
          o_clp = clip;
        end
      end
      @(posedge clk_49m); #1;
      cyc++;
    end
    sample_cen = 1'b0;
    mute       = 1'b0;
    reset      = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sample_cen = 1'b0; mute = 1'b0; clip_clr = 1'b0;
    clear_ch();
    repeat (3) @(posedge clk_49m);
    #1 reset = 1'b0;

    chk("rst_sound", sound, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_clip", clip, 0);
    chk("rst_overrun", overrun, 0);

    // Unity pass-through and latency
    set_ch(0, 1000, GAIN_UNITY, 1'b0, 1'b0);
    do_pass(0, 0, 0, lat, pulses, snd, clp);
    chk("unity_lat", lat, 6);
    chk("unity_pulses", pulses, 1);
    chk("unity_sound", snd, 1000);
    chk("unity_hold", sound, 1000);

    // Sum, invert and half gain: 3000 - 2000 + 200
    set_ch(0, 3000, GAIN_UNITY, 1'b0, 1'b0);
    set_ch(1, 2000, GAIN_UNITY, 1'b1, 1'b0);
    set_ch(2, 400, 8'h08, 1'b0, 1'b0);
    do_pass(0, 0, 0, lat, pulses, snd, clp);
    chk("suminv_sound", snd, 1200);
    chk("suminv_clip", clp, 0);

    // Truncation toward -inf
    clear_ch();
    set_ch(0, -1, 8'h08, 1'b0, 1'b0);
    do_pass(0, 0, 0, lat, pulses, snd, clp);
    chk("trunc_neg", snd, -1);
    set_ch(0, 1, 8'h08, 1'b0, 1'b0);
    do_pass(0, 0, 0, lat, pulses, snd, clp);
    chk("trunc_pos", snd, 0);

    // Positive saturation and sticky clip
    set_ch(0, 30000, 8'h20, 1'b0, 1'b0);
    set_ch(1, 30000, 8'h20, 1'b0, 1'b0);
    do_pass(0, 0, 0, lat, pulses, snd, clp);
    chk("sat_hi_sound", snd, 32767);
    chk("sat_hi_clip", clp, 1);
    set_ch(0, 3000, GAIN_UNITY, 1'b0, 1'b0);
    set_ch(1, 2000, GAIN_UNITY, 1'b1, 1'b0);
    set_ch(2, 400, 8'h08, 1'b0, 1'b0);
    do_pass(0, 0, 0, lat, pulses, snd, clp);
    chk("sticky_sound", snd, 1200);
    chk("sticky_clip", clip, 1);

    // Negative saturation and negated most-negative input
    clear_ch();
    set_ch(0, -30000, 8'h20, 1'b0, 1'b0);
    set_ch(1, -30000, 8'h20, 1'b0, 1'b0);
    do_pass(0, 0, 0, lat, pulses, snd, clp);
    chk("sat_lo_sound", snd, -32768);
    clear_ch();
    set_ch(0, -32768, GAIN_UNITY, 1'b1, 1'b0);
    do_pass(0, 0, 0, lat, pulses, snd, clp);
    chk("invmin_sound", snd, 32767);

    // clip_clr, then clip_clr held through a clipping OUTPUT cycle
    clip_clr = 1'b1;
    @(posedge clk_49m); #1;
    chk("clr_clip", clip, 0);
    clear_ch();
    set_ch(0, 30000, 8'h20, 1'b0, 1'b0);
    set_ch(1, 30000, 8'h20, 1'b0, 1'b0);
    do_pass(0, 0, 0, lat, pulses, snd, clp);
    chk("setwins_clip", clp, 1);
    chk("clr_held_clip", clip, 0);
    clip_clr = 1'b0;

    // Mute during OUTPUT: zero output, no clip evaluation
    do_pass(5, 0, 0, lat, pulses, snd, clp);
    chk("mute_sound", snd, 0);
    chk("mute_pulses", pulses, 1);
    chk("mute_clip", clip, 0);

    // Overrun at t+3, then back-to-back strobe at t+6 accepted
    clear_ch();
    set_ch(0, 1000, GAIN_UNITY, 1'b0, 1'b0);
    do_pass(0, 3, 0, lat, pulses, snd, clp);
    chk("ovr_pulses", pulses, 1);
    chk("ovr_sound", snd, 1000);
    chk("ovr_flag", overrun, 1);
    clip_clr = 1'b1;
    @(posedge clk_49m); #1;
    clip_clr = 1'b0;
    chk("ovr_clr", overrun, 0);
    do_pass(0, 6, 0, lat, pulses, snd, clp);
    chk("b2b_pulses", pulses, 2);
    chk("b2b_overrun", overrun, 0);

    // Reset mid-pass, then a clean pass
    do_pass(0, 0, 2, lat, pulses, snd, clp);
    chk("midrst_pulses", pulses, 0);
    chk("midrst_sound", sound, 0);
    chk("midrst_valid", sample_valid, 0);
    do_pass(0, 0, 0, lat, pulses, snd, clp);
    chk("postrst_sound", snd, 1000);

    // Muted pass still advances the tracker
    do_reset();
    clear_ch();
    set_ch(0, 8000, GAIN_UNITY, 1'b0, 1'b1);
    do_pass(5, 0, 0, lat, pulses, snd, clp);
    chk("dcmute_sound", snd, 0);
    do_pass(0, 0, 0, lat, pulses, snd, clp);
    chk("dcmute_next", snd, 7500);

    // DC removal decay from a fresh tracker
    do_reset();
    do_pass(0, 0, 0, lat, pulses, snd, clp);
    chk("dc_first", snd, 8000);
    do_pass(0, 0, 0, lat, pulses, snd, clp);
    chk("dc_second", snd, 7500);
    prev = snd;
    for (int i = 2; i < 200; i++) begin
      do_pass(0, 0, 0, lat, pulses, snd, clp);
      chk("dc_mono", (snd <= prev) && (snd >= 0), 1);
      prev = snd;
    end
    chk("dc_settle", (prev <= 16) && (prev >= -16), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/konami_audio_mixer.md
# konami_audio_mixer

Parametrised, time-multiplexed audio mixer for the arcade PCB models. It replaces the hand-wired per-board mix of one PSG channel and one speech channel with fixed shifts. It takes N signed sound-chip outputs and, per channel, applies optional DC-offset removal, optional phase inversion and an 8-bit Q4.4 gain. It then sums the channels, saturates the total and emits one registered sample per sample strobe. It sits between the sound chips/filters and the top-level `sound` output, and adds an explicit pause mute plus clip and overrun status.

## Interface
Parameters:
- CHANNELS, 4, number of input channels (1..8)
- IN_W, 16, width of each signed input sample
- OUT_W, 16, width of the signed output sample
- DCRM_SHIFT, 10, DC-tracker time constant, 2^DCRM_SHIFT samples

Ports:
- clk_49m  in  1  sole clock (49.152 MHz)
- reset  in  1  synchronous, active-high reset
- sample_cen  in  1  one-cycle sample strobe; starts one mix pass
- ch_in  in  CHANNELS*IN_W  packed signed samples; channel k is at bits [k*IN_W +: IN_W]
- ch_gain  in  CHANNELS*8  packed unsigned Q4.4 gain per channel; 8'h10 = 1.0
- ch_invert  in  CHANNELS  per-channel negate
- ch_dcrm_en  in  CHANNELS  per-channel DC removal enable
- mute  in  1  pause mute
- clip_clr  in  1  clears the sticky status flags
- sound  out  OUT_W  signed mixed sample, registered
- sample_valid  out  1  one-cycle pulse when `sound` updates
- clip  out  1  sticky: saturation occurred
- overrun  out  1  sticky: sample_cen arrived while busy

## Operation
- State machine:
  - IDLE: a sample_cen snapshots ch_in, ch_gain, ch_invert and ch_dcrm_en into a holding register, clears the accumulator, sets idx=0 and moves to ACCUM.
  - ACCUM: processes channel idx each cycle. When idx = CHANNELS-1 it moves to OUTPUT.
  - OUTPUT: scales, saturates and registers the result, then returns to IDLE.
- Per-channel datapath (channel k, held sample x):
  - DC removal: tracker acc_k is IN_W+DCRM_SHIFT bits signed. dc = acc_k >>> DCRM_SHIFT (arithmetic).
    - If ch_dcrm_en[k]: y = x − dc, width IN_W+1. The tracker updates once per pass: acc_k += x − dc.
    - Else: y = x (sign-extended), and acc_k holds its value.
  - Inversion: z = ch_invert[k] ? −y : y, width IN_W+2, so negating the most negative value cannot overflow.
  - Gain: p = z × gain, where gain is unsigned and zero-extended; product width IN_W+10.
  - Accumulate: sum += p. ACC_W = IN_W+10+clog2(CHANNELS). The accumulator never wraps.
- Output stage:
  - r = sum >>> 4, arithmetic shift that truncates toward −inf.
  - Saturate r to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. Any saturation sets clip.
  - If mute: sound <= 0, no clip evaluation, and the DC trackers still update.
- Status flags:
  - sample_cen in ACCUM or OUTPUT is ignored and sets overrun.
  - clip_clr clears clip and overrun. If a set condition occurs in the same cycle, the set wins.

## Timing
- Reset values: sound=0, sample_valid=0, clip=0, overrun=0, state=IDLE, all acc_k=0, sum=0.
- Latency: sample_cen at cycle t gives sample_valid and the new sound at cycle t+CHANNELS+2. Inputs are sampled only at cycle t.
- Throughput: sample_cen spacing must be at least CHANNELS+2 cycles. A strobe at exactly t+CHANNELS+2 is accepted, because the FSM is back in IDLE.
- Hold: sound holds its value between sample_valid pulses.
- Mute: takes effect on the output of the pass whose OUTPUT cycle sees mute=1. It is not taken from the snapshot.
- Reset mid-pass: returns to IDLE at the next edge with no sample_valid, and clears the trackers.
- CHANNELS=1: ACCUM lasts exactly one cycle.

## Structure
- Package konami_audio_pkg:
  - mixer_state_t enum (IDLE, ACCUM, OUTPUT)
  - function acc_width(in_w, channels)
  - localparam GAIN_UNITY = 8'h10
- Sub-module konami_dcrm_bank: holds CHANNELS tracker registers, indexed by idx, with a read port returning y and an update-enable. The top module holds the FSM, the multiply-accumulate, saturation and flags.

## Test plan
- Unity pass-through: CHANNELS=4, channel 0 = 16'sd1000 with gain 8'h10, other gains 0, DC removal off. Strobe → sound=1000 at t+6 with a single sample_valid pulse.
- Sum and invert: ch0=3000, ch1=2000 with invert, both at gain 8'h10; gain 8'h08 on ch2=400 → sound=1200.
- Saturation: ch0=ch1=16'sd30000, both at gain 8'h20 → sound=32767 and clip=1. clip stays 1 until clip_clr; clip_clr asserted in the same cycle as a new clip keeps clip=1.
- DC removal: constant ch0=16'sd8000 with DC removal on, DCRM_SHIFT=4. First output is 8000, decaying monotonically to |sound| ≤ 16 within 200 strobes.
- Overrun and mute: strobe at t and again at t+3 → overrun=1 and exactly one sample_valid. mute=1 during the OUTPUT cycle → sound=0 while trackers keep updating.
- Reset mid-pass: reset at t+2 → no sample_valid, all outputs 0. The next strobe then yields a correct result.
